// File: rtl/sseg_pkg.sv
// Shared types and constants for the seven-segment scan path.
// Scan FSM states, all-off bus values and the hex glyph table.
package sseg_pkg;

  typedef enum logic {
    BLANK,
    SHOW
  } state_e;

  localparam logic [7:0] SEG_OFF = 8'hFF;
  localparam logic [7:0] AN_OFF  = 8'hFF;

  // Active-low gfedcba glyphs; entry n is the glyph for hex digit n.
  localparam logic [15:0][6:0] SEG_TABLE = {
    7'b0001110,  // F
    7'b0000110,  // E
    7'b0100001,  // d
    7'b1000110,  // C
    7'b0000011,  // b
    7'b0001000,  // A
    7'b0010000,  // 9
    7'b0000000,  // 8
    7'b1111000,  // 7
    7'b0000010,  // 6
    7'b0010010,  // 5
    7'b0011001,  // 4
    7'b0110000,  // 3
    7'b0100100,  // 2
    7'b1111001,  // 1
    7'b1000000   // 0
  };

endpackage

// File: rtl/hex_to_sseg.sv
// Nibble plus decimal point to active-low cathode pattern.
// Ports: nibble (hex value), dp (1 = lit), seg ([7] = DP, [6:0] = g..a).
module hex_to_sseg
  import sseg_pkg::*;
(
  input  logic [3:0] nibble,
  input  logic       dp,
  output logic [7:0] seg
);

  assign seg = {~dp, SEG_TABLE[nibble]};

endmodule

// File: rtl/seven_seg_scan_ctrl.sv
// Eight-digit time-multiplexed display scanner with blanking and a
// frame-synchronous double buffer loaded through LOAD/PENDING.
// Ports: CLK, RST (sync, active-high), DIGITS/DP/DIG_EN + LOAD in;
// PENDING, FRAME_TICK, SSEG_CA, SSEG_AN (active-low) out.
module seven_seg_scan_ctrl
  import sseg_pkg::*;
#(
  parameter int CLK_DIV      = 100000,
  parameter int BLANK_CYCLES = 1000,
  parameter int NUM_DIGITS   = 8
) (
  input  logic        CLK,
  input  logic        RST,
  input  logic [31:0] DIGITS,
  input  logic [7:0]  DP,
  input  logic [7:0]  DIG_EN,
  input  logic        LOAD,
  output logic        PENDING,
  output logic        FRAME_TICK,
  output logic [7:0]  SSEG_CA,
  output logic [7:0]  SSEG_AN
);

  localparam int CW = $clog2(CLK_DIV);
  localparam logic [CW-1:0] SLOT_LAST  = CW'(CLK_DIV - 1);
  localparam logic [CW-1:0] BLANK_LAST = CW'(BLANK_CYCLES - 1);
  localparam logic [2:0]    IDX_LAST   = 3'(NUM_DIGITS - 1);

  state_e        state, state_nxt;
  logic [CW-1:0] cnt, cnt_nxt;
  logic [2:0]    idx, idx_nxt;

  logic [31:0] stg_digits, shd_digits;
  logic [7:0]  stg_dp, shd_dp;
  logic [7:0]  stg_en, shd_en;

  logic [3:0] nib_nxt;
  logic [7:0] seg_nxt;
  logic [7:0] an_nxt, ca_nxt;
  logic       tick_nxt;

  // cnt runs across the whole slot; BLANK owns its first BLANK_CYCLES.
  always_comb begin
    state_nxt = state;
    cnt_nxt   = cnt + 1'b1;
    idx_nxt   = idx;
    unique case (state)
      BLANK: begin
        if (cnt == BLANK_LAST) state_nxt = SHOW;
      end
      SHOW: begin
        if (cnt == SLOT_LAST) begin
          state_nxt = BLANK;
          cnt_nxt   = '0;
          idx_nxt   = idx + 3'd1;
        end
      end
      default: state_nxt = BLANK;
    endcase
  end

  assign nib_nxt = shd_digits[{idx_nxt, 2'b00} +: 4];

  hex_to_sseg u_dec (
    .nibble(nib_nxt),
    .dp    (shd_dp[idx_nxt]),
    .seg   (seg_nxt)
  );

  // Outputs are registered from the next state so they line up with it.
  always_comb begin
    an_nxt   = AN_OFF;
    ca_nxt   = SEG_OFF;
    tick_nxt = 1'b0;
    if (state_nxt == SHOW && shd_en[idx_nxt]) begin
      an_nxt = ~(8'h01 << idx_nxt);
      ca_nxt = seg_nxt;
    end
    if (state_nxt == SHOW && cnt_nxt == SLOT_LAST && idx_nxt == IDX_LAST)
      tick_nxt = 1'b1;
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      state      <= BLANK;
      cnt        <= '0;
      idx        <= '0;
      SSEG_AN    <= AN_OFF;
      SSEG_CA    <= SEG_OFF;
      FRAME_TICK <= 1'b0;
      PENDING    <= 1'b0;
      stg_digits <= '0;
      stg_dp     <= '0;
      stg_en     <= '0;
      shd_digits <= '0;
      shd_dp     <= '0;
      shd_en     <= '0;
    end else begin
      state      <= state_nxt;
      cnt        <= cnt_nxt;
      idx        <= idx_nxt;
      SSEG_AN    <= an_nxt;
      SSEG_CA    <= ca_nxt;
      FRAME_TICK <= tick_nxt;
      // FRAME_TICK high marks the current cycle as the frame boundary.
      if (FRAME_TICK && PENDING) begin
        shd_digits <= stg_digits;
        shd_dp     <= stg_dp;
        shd_en     <= stg_en;
        PENDING    <= 1'b0;
      end else if (LOAD && !PENDING) begin
        stg_digits <= DIGITS;
        stg_dp     <= DP;
        stg_en     <= DIG_EN;
        PENDING    <= 1'b1;
      end
    end
  end

endmodule
